// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing controller: ALU control codes,
// data width and the controller FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTL_W  = 4;

  localparam logic [CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTL_W-1:0] ALU_DIV = 4'd3;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [CTL_W-1:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between the two
// requesters, the response consumer, the ALU and the sharing controller.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  // Handshake: a request or response transfers on a rising edge where valid
  // and ready are both high. req_ready is a one-hot, single-cycle accept
  // strobe; a requester keeps req_valid and its operands steady until then.
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*CTL_W-1:0]  req_ctl;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_zero;
  logic [CTL_W-1:0]    alu_ctl;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;

  modport slave (
    input  req_valid, req_ctl, req_a, req_b, rsp_ready, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero,
           alu_ctl, alu_a, alu_b
  );

  modport master (
    output req_valid, req_ctl, req_a, req_b, rsp_ready, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero,
           alu_ctl, alu_a, alu_b
  );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle; only
// built when ALU_ARB_DIV_EN is defined. Divide by zero yields all ones.
`ifdef ALU_ARB_DIV_EN
module seq_divider
  import alu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] diff;
    logic              unused_diff;

    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
        // A non-negative difference means the divisor fits: keep it, emit a 1.
        if (!diff[DATA_W+1]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    assign unused_diff = diff[DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(DIV_CYCLES);
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
        end
    end

    // The final iteration's result is handed out combinationally with done.
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient = quo_d;

endmodule
`endif

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters with a
// registered, id-tagged response. Define ALU_ARB_DIV_EN to run divides on an
// internal sequential divider instead of the ALU.
module alu_share_arbiter
  import alu_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output state_e              state_o
);

    localparam int ID_W = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id, last_grant_q;
    logic              any_req;
    logic              is_div;
    logic [CTL_W-1:0]  sel_ctl;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [1:0]        req_ready_c;
    logic              rsp_valid_c;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_zero_q;
    logic [CTL_W-1:0]  alu_ctl_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic              unused_alu_zero;

    assign unused_alu_zero = bus.alu_zero;

    // Tie goes to whoever was not granted last.
    always_comb begin
        any_req = |bus.req_valid;
        if (&bus.req_valid) grant_id = ~last_grant_q;
        else                grant_id = bus.req_valid[0] ? '0 : '1;
        sel_ctl = grant_id[0] ? bus.req_ctl[7:4]   : bus.req_ctl[3:0];
        sel_a   = grant_id[0] ? bus.req_a[63:32]   : bus.req_a[31:0];
        sel_b   = grant_id[0] ? bus.req_b[63:32]   : bus.req_b[31:0];
    end

`ifdef ALU_ARB_DIV_EN
    logic              div_done;
    logic              unused_div_busy;
    logic [DATA_W-1:0] div_quo;

    assign is_div = (sel_ctl == ALU_DIV);

    seq_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    ((state_q == ST_IDLE) && any_req && is_div),
        .dividend (sel_a),
        .divisor  (sel_b),
        .busy     (unused_div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );
`else
    localparam int unused_div_cycles = DIV_CYCLES;
    assign is_div = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = is_div ? ST_DIV : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
`ifdef ALU_ARB_DIV_EN
            ST_DIV:  if (div_done) state_d = ST_RESP;
`endif
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = '0;
        if ((state_q == ST_IDLE) && any_req && !rst) req_ready_c[grant_id] = 1'b1;
        rsp_valid_c = (state_q == ST_RESP);
    end

    // Divides never load the ALU registers, so the ALU never sees ctl 3 then.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= '1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            alu_ctl_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
        end else begin
            if ((state_q == ST_IDLE) && any_req) begin
                last_grant_q <= grant_id;
                rsp_id_q     <= grant_id[0];
                if (!is_div) begin
                    alu_ctl_q <= sel_ctl;
                    alu_a_q   <= sel_a;
                    alu_b_q   <= sel_b;
                end
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q <= bus.alu_out;
                rsp_zero_q <= (bus.alu_out == '0);
            end
`ifdef ALU_ARB_DIV_EN
            if ((state_q == ST_DIV) && div_done) begin
                rsp_data_q <= div_quo;
                rsp_zero_q <= (div_quo == '0);
            end
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.alu_ctl   = alu_ctl_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, directed multi-cycle sequences
// and randomized traffic checked against an arithmetic reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DIV_CYCLES = 32;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_dbg;

  alu_share_arbiter_if bus();

  alu_share_arbiter #(.NREQ(2), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  logic [3:0]  ctl_r [2];
  logic [31:0] a_r   [2];
  logic [31:0] b_r   [2];

  function automatic logic [31:0] ref_result(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU model; a divide leaking to it under the divider build is poisoned.
  function automatic logic [31:0] alu_env(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ARB_DIV_EN
    if (ctl == ALU_DIV) return 32'hBAD0_0003;
`endif
    return ref_result(ctl, a, b);
  endfunction

  always_comb begin
    bus.req_ctl  = {ctl_r[1], ctl_r[0]};
    bus.req_a    = {a_r[1], a_r[0]};
    bus.req_b    = {b_r[1], b_r[0]};
    bus.alu_out  = alu_env(bus.alu_ctl, bus.alu_a, bus.alu_b);
    bus.alu_zero = (alu_env(bus.alu_ctl, bus.alu_a, bus.alu_b) == 32'd0);
  end

`ifdef ALU_ARB_DIV_EN
  bit alu_saw_div = 1'b0;
  always @(negedge clk) if (!rst && bus.alu_ctl == ALU_DIV) alu_saw_div = 1'b1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int model_last = 1;
  logic [33:0] exp_q[$];

  typedef struct {
    int          id;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_zero;
    int          hold;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has driven req_valid/operands in an IDLE cycle; serve one transaction.
  task automatic serve(input int exp_id, input logic [31:0] exp_data, input logic exp_zero,
                       input int hold, input logic other_valid, input string name);
    int          other;
    int          lat;
    int          exp_lat;
    bit          is_div;
    logic [33:0] e;
    other  = 1 - exp_id;
    is_div = 1'b0;
`ifdef ALU_ARB_DIV_EN
    is_div = (ctl_r[exp_id] == ALU_DIV);
`endif
    exp_lat = is_div ? DIV_CYCLES : 1;
    exp_q.push_back({exp_id[0], exp_zero, exp_data});
    #1;
    check({name, " req_ready"}, 32'(bus.req_ready), 32'(2'b01 << exp_id));
    model_last = exp_id;
    step();
    bus.req_valid[exp_id] = 1'b0;
    bus.req_valid[other]  = other_valid;
    bus.rsp_ready = 1'b0;
    if (!is_div) begin
      check({name, " alu_ctl"}, 32'(bus.alu_ctl), 32'(ctl_r[exp_id]));
      check({name, " alu_a"}, bus.alu_a, a_r[exp_id]);
      check({name, " alu_b"}, bus.alu_b, b_r[exp_id]);
      check({name, " state_exec"}, 32'(state_dbg), 32'(ST_EXEC));
    end
    lat = 0;
    while (!bus.rsp_valid && lat < 60) begin
      step();
      lat++;
    end
    e = exp_q.pop_front();
    if (!bus.rsp_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s rsp_timeout: got no rsp_valid, want one within 60 cycles", name);
      bus.req_valid = 2'b00;
      return;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    for (int h = 0; h <= hold; h++) begin
      check({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({name, " rsp_id"}, 32'(bus.rsp_id), 32'(e[33]));
      check({name, " rsp_data"}, bus.rsp_data, e[31:0]);
      check({name, " rsp_zero"}, 32'(bus.rsp_zero), 32'(e[32]));
      check({name, " ready_in_resp"}, 32'(bus.req_ready), 32'd0);
      if (h < hold) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check({name, " rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    check({name, " state_idle"}, 32'(state_dbg), 32'(ST_IDLE));
    bus.rsp_ready = 1'b0;
  endtask

  task automatic rand_op(input int id);
    logic [3:0] ctls [9];
    ctls = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd5, 4'd15};
    ctl_r[id] = ctls[$urandom_range(0, 8)];
    a_r[id] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
    b_r[id] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, want finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          id;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ctl_r[i] = '0;
      a_r[i]   = '0;
      b_r[i]   = '0;
    end
    repeat (3) step();
    bus.req_valid = 2'b11;
    #1;
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst rsp_data", bus.rsp_data, 32'd0);
    check("rst rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst alu_ctl", 32'(bus.alu_ctl), 32'd0);
    check("rst alu_a", bus.alu_a, 32'd0);
    check("rst alu_b", bus.alu_b, 32'd0);
    check("rst state", 32'(state_dbg), 32'(ST_IDLE));
    bus.req_valid = 2'b00;
    step();
    rst = 1'b0;
    model_last = 1;
    step();

    // First tie after reset goes to requester 0.
    ctl_r[0] = ALU_SUB; a_r[0] = 32'd44;   b_r[0] = 32'd18;
    ctl_r[1] = ALU_AND; a_r[1] = 32'd4515; b_r[1] = 32'd777;
    bus.req_valid = 2'b11;
    serve(0, 32'd26, 1'b0, 0, 1'b1, "tie0");
    serve(1, 32'd257, 1'b0, 0, 1'b0, "tie1");

    vecs[0] = '{0, ALU_ADD, 32'd34, 32'd47, 32'd81, 1'b0, 0};
    vecs[1] = '{1, ALU_SUB, 32'd1000, 32'd1, 32'd999, 1'b0, 1};
    vecs[2] = '{0, ALU_SLT, 32'd3, 32'd9, 32'd1, 1'b0, 0};
    vecs[3] = '{1, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 2};
    vecs[4] = '{0, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 0};
    vecs[5] = '{1, 4'd5, 32'd123, 32'd456, 32'd0, 1'b1, 0};
    vecs[6] = '{0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1};
    vecs[7] = '{1, ALU_SLT, 32'hFFFF_FFFE, 32'd2, 32'd1, 1'b0, 0};
    for (int i = 0; i < 8; i++) begin
      ctl_r[vecs[i].id] = vecs[i].ctl;
      a_r[vecs[i].id]   = vecs[i].a;
      b_r[vecs[i].id]   = vecs[i].b;
      bus.req_valid     = 2'b01 << vecs[i].id;
      serve(vecs[i].id, vecs[i].exp_data, vecs[i].exp_zero, vecs[i].hold, 1'b0, "vec");
    end

    // Backpressure with requester 0 waiting throughout the response.
    ctl_r[1] = ALU_SLT; a_r[1] = 32'd9584; b_r[1] = 32'd1888;
    ctl_r[0] = ALU_ADD; a_r[0] = 32'd5;    b_r[0] = 32'd6;
    bus.req_valid = 2'b10;
    serve(1, 32'd0, 1'b1, 5, 1'b1, "bp");
    serve(0, 32'd11, 1'b0, 0, 1'b0, "bp_wait");

    // Fairness: both held valid, grants must alternate.
    rand_op(0);
    rand_op(1);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      id = (model_last == 0) ? 1 : 0;
      r  = ref_result(ctl_r[id], a_r[id], b_r[id]);
      serve(id, r, (r == 32'd0), $urandom_range(0, 2), 1'b1, "fair");
      rand_op(id);
      bus.req_valid[id] = 1'b1;
    end
    bus.req_valid = 2'b00;

    for (int t = 0; t < 20; t++) begin
      id = $urandom_range(0, 1);
      rand_op(id);
      bus.req_valid = 2'b01 << id;
      r = ref_result(ctl_r[id], a_r[id], b_r[id]);
      serve(id, r, (r == 32'd0), $urandom_range(0, 3), 1'b0, "rand");
    end

`ifdef ALU_ARB_DIV_EN
    ctl_r[0] = ALU_DIV; a_r[0] = 32'd100; b_r[0] = 32'd7;
    bus.req_valid = 2'b01;
    serve(0, 32'd14, 1'b0, 0, 1'b0, "div100_7");
    ctl_r[1] = ALU_DIV; a_r[1] = 32'd5; b_r[1] = 32'd0;
    bus.req_valid = 2'b10;
    serve(1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, "div_by0");
    ctl_r[0] = ALU_DIV; a_r[0] = 32'hFFFF_FFFF; b_r[0] = 32'd3;
    bus.req_valid = 2'b01;
    serve(0, 32'h5555_5555, 1'b0, 0, 1'b0, "div_big");
    check("alu_never_div", 32'(alu_saw_div), 32'd0);
`endif

    // Reset while in EXEC abandons the operation.
    ctl_r[1] = ALU_ADD; a_r[1] = 32'd5; b_r[1] = 32'd9;
    bus.req_valid = 2'b10;
    #1;
    check("mid_rst req_ready", 32'(bus.req_ready), 32'b10);
    step();
    bus.req_valid = 2'b00;
    check("mid_rst in_exec", 32'(state_dbg), 32'(ST_EXEC));
    rst = 1'b1;
    step();
    check("mid_rst state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst rsp_id", 32'(bus.rsp_id), 32'd0);
    check("mid_rst rsp_data", bus.rsp_data, 32'd0);
    check("mid_rst rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("mid_rst alu_ctl", 32'(bus.alu_ctl), 32'd0);
    check("mid_rst alu_a", bus.alu_a, 32'd0);
    check("mid_rst alu_b", bus.alu_b, 32'd0);
    rst = 1'b0;
    model_last = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    ctl_r[0] = ALU_ADD; a_r[0] = 32'd1; b_r[0] = 32'd1;
    ctl_r[1] = ALU_ADD; a_r[1] = 32'd3; b_r[1] = 32'd3;
    bus.req_valid = 2'b11;
    serve(0, 32'd2, 1'b0, 0, 1'b1, "post_rst_tie0");
    serve(1, 32'd6, 1'b0, 0, 1'b0, "post_rst_tie1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
